// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_pkg                                                         |
// | Purpose : Shared types and constants for the UART receive deframer:       |
// |           receiver FSM state encoding, Rx_Error bit positions and the     |
// |           oversample tick divider calculation.                            |
// | Ports   : none (package)                                                  |
// | Rev     : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5,
    BREAK  = 3'd6
  } rx_state_e;

  // Bit positions inside Rx_Error
  localparam int ERR_PARITY  = 0;
  localparam int ERR_FRAMING = 1;
  localparam int ERR_OVERRUN = 2;

  // SysClk cycles per oversample tick, truncated. Zero means the clock is too
  // slow for the requested line rate.
  function automatic int calc_div(input int sysclk, input int baud, input int os);
    return sysclk / (baud * os);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rx_tick                                                     |
// | Purpose : Free-running divider producing a one-cycle oversample Tick      |
// |           every DIV SysClk cycles. Restart zeroes the count so the first  |
// |           Tick lands DIV cycles after the cycle Restart was high.         |
// | Ports   : SysClk  in  system clock                                        |
// |           Rst_n   in  asynchronous active-low reset                       |
// |           Restart in  synchronous counter restart                         |
// |           Tick    out one-cycle oversample strobe                         |
// | Rev     : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_rx_tick #(
  parameter int DIV = 4
) (
  input  logic SysClk,
  input  logic Rst_n,
  input  logic Restart,
  output logic Tick
);

  localparam int              c_CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

  logic [c_CW-1:0] r_cnt;

  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt <= '0;
    end else if (Restart || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Suppressed on the restart cycle so a stale phase never leaks into START
  assign Tick = ~Restart & (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rx_deframer                                                 |
// | Purpose : UART receive deserializer. Synchronizes Rx, validates the start |
// |           bit at its centre, shifts in DATA_BITS MSB first, checks even   |
// |           parity and stop bits, and writes each character to the Rx FIFO |
// |           with per-frame parity / framing / overrun status.              |
// | Ports   : SysClk     in  system clock                                     |
// |           Rst_n      in  asynchronous active-low reset                    |
// |           Rx         in  serial line, idle high, async to SysClk         |
// |           FIFO_Full  in  Rx FIFO cannot accept a write                    |
// |           Rx_Data    out received character (valid with Rx_Valid)       |
// |           Rx_Valid   out one-cycle FIFO write strobe                     |
// |           Rx_Error   out {overrun, framing, parity}, held between frames |
// |           Err_Strobe out one-cycle pulse when a frame ends in error      |
// |           Busy       out frame in progress after a valid start bit      |
// | Rev     : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int SYSCLK_RATE = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_BIT  = 1,
  parameter int STOP_BITS   = 2
) (
  input  logic                 SysClk,
  input  logic                 Rst_n,
  input  logic                 Rx,
  input  logic                 FIFO_Full,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Rx_Valid,
  output logic [2:0]           Rx_Error,
  output logic                 Err_Strobe,
  output logic                 Busy
);

  localparam int c_DIV      = calc_div(SYSCLK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int c_DIV_SAFE = (c_DIV > 0) ? c_DIV : 1;
  localparam int c_TCW      = $clog2(OVERSAMPLE);
  localparam int c_BCW      = $clog2(DATA_BITS + STOP_BITS + 1);

  localparam logic [c_TCW-1:0] c_HALF_LAST = c_TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [c_TCW-1:0] c_FULL_LAST = c_TCW'(OVERSAMPLE - 1);
  localparam logic [c_BCW-1:0] c_DATA_LAST = c_BCW'(DATA_BITS - 1);
  localparam logic [c_BCW-1:0] c_STOP_LAST = c_BCW'(STOP_BITS - 1);

  if (c_DIV == 0) begin : g_div_check
    $error("uart_rx_deframer: SYSCLK_RATE too low for BAUD_RATE*OVERSAMPLE");
  end

  rx_state_e r_state, w_state_nxt;

  logic                 r_rx_meta, r_rx_sync;
  logic [c_TCW-1:0]     r_tick_cnt;
  logic [c_BCW-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity_err, r_framing;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_err_strobe;
  logic [2:0]           r_rx_error;

  logic             w_tick, w_restart, w_sample, w_frame_end, w_framing_final;
  logic [c_TCW-1:0] w_target;
  logic [2:0]       w_err_nxt;

  // Two-flop synchronizer, idles high so reset never looks like a start edge
  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= Rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  uart_rx_tick #(
    .DIV (c_DIV_SAFE)
  ) u_tick (
    .SysClk  (SysClk),
    .Rst_n   (Rst_n),
    .Restart (w_restart),
    .Tick    (w_tick)
  );

  // Start bit is sampled half a bit after the edge, every later bit one full
  // bit after the previous sample, i.e. always at the bit centre.
  assign w_target = (r_state == START) ? c_HALF_LAST : c_FULL_LAST;
  assign w_sample = w_tick & (r_tick_cnt == w_target);

  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_restart || w_sample) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      // Level test: a low line seen in IDLE is a start edge, which also
      // catches an edge that arrived while DONE was being processed.
      IDLE: begin
        if (!r_rx_sync) begin
          w_state_nxt = START;
          w_restart   = 1'b1;
        end
      end
      START: begin
        if (w_sample) begin
          w_state_nxt = r_rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_sample && (r_bit_cnt == c_DATA_LAST)) begin
          w_state_nxt = (PARITY_BIT != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (w_sample) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_sample && (r_bit_cnt == c_STOP_LAST)) begin
          w_state_nxt = DONE;
          w_frame_end = 1'b1;
        end
      end
      DONE: begin
        // Framing error on an all-zero character is a line break
        w_state_nxt = (r_framing && (r_shift == '0)) ? BREAK : IDLE;
      end
      BREAK: begin
        if (r_rx_sync) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status of the frame being closed, including the final stop sample
  assign w_framing_final = r_framing | ~r_rx_sync;

  always_comb begin
    w_err_nxt              = '0;
    w_err_nxt[ERR_PARITY]  = r_parity_err;
    w_err_nxt[ERR_FRAMING] = w_framing_final;
    w_err_nxt[ERR_OVERRUN] = FIFO_Full;
  end

  // Datapath. Outputs are registered on the edge that enters DONE so the
  // strobes, data and status are all presented during the DONE cycle.
  // FIFO_Full is therefore taken from the cycle that closes the frame.
  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity_err <= 1'b0;
      r_framing    <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_err_strobe <= 1'b0;
      r_rx_error   <= '0;
    end else begin
      r_rx_valid   <= 1'b0;
      r_err_strobe <= 1'b0;

      if (w_restart) begin
        r_bit_cnt    <= '0;
        r_parity_err <= 1'b0;
        r_framing    <= 1'b0;
      end

      if (w_sample) begin
        case (r_state)
          DATA: begin
            r_shift   <= (r_shift << 1) | DATA_BITS'(r_rx_sync);
            r_bit_cnt <= (r_bit_cnt == c_DATA_LAST) ? '0 : r_bit_cnt + 1'b1;
          end
          PARITY: begin
            r_parity_err <= r_rx_sync ^ (^r_shift);
          end
          STOP: begin
            if (!r_rx_sync) begin
              r_framing <= 1'b1;
            end
            r_bit_cnt <= (r_bit_cnt == c_STOP_LAST) ? '0 : r_bit_cnt + 1'b1;
          end
          default: ;
        endcase
      end

      if (w_frame_end) begin
        r_rx_valid   <= ~FIFO_Full;
        r_err_strobe <= |w_err_nxt;
        r_rx_error   <= w_err_nxt;
        if (!FIFO_Full) begin
          r_rx_data <= r_shift;
        end
      end
    end
  end

  assign Rx_Data    = r_rx_data;
  assign Rx_Valid   = r_rx_valid;
  assign Rx_Error   = r_rx_error;
  assign Err_Strobe = r_err_strobe;
  assign Busy       = (r_state == DATA) || (r_state == PARITY) || (r_state == STOP);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_rx_deframer                                              |
// | Purpose : Self-checking bench for uart_rx_deframer. Table of clean and   |
// |           errored frames plus directed sequences for break, glitch,     |
// |           back-to-back frames and reset mid-frame.                       |
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_uart_rx_deframer;

  localparam int c_BAUD  = 115_200;
  localparam int c_OS    = 16;
  localparam int c_SYS   = 16 * c_BAUD * 4;   // DIV = 4
  localparam int c_BIT   = c_OS * 4;          // SysClk cycles per bit

  logic       SysClk = 1'b0;
  logic       Rst_n;
  logic       Rx;
  logic       FIFO_Full;
  logic [7:0] Rx_Data;
  logic       Rx_Valid;
  logic [2:0] Rx_Error;
  logic       Err_Strobe;
  logic       Busy;

  uart_rx_deframer #(
    .SYSCLK_RATE (c_SYS),
    .BAUD_RATE   (c_BAUD),
    .OVERSAMPLE  (c_OS),
    .DATA_BITS   (8),
    .PARITY_BIT  (1),
    .STOP_BITS   (2)
  ) dut (
    .SysClk     (SysClk),
    .Rst_n      (Rst_n),
    .Rx         (Rx),
    .FIFO_Full  (FIFO_Full),
    .Rx_Data    (Rx_Data),
    .Rx_Valid   (Rx_Valid),
    .Rx_Error   (Rx_Error),
    .Err_Strobe (Err_Strobe),
    .Busy       (Busy)
  );

  always #5 SysClk = ~SysClk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_valid;
  int         n_strobe;
  logic       busy_seen;
  logic [7:0] q_data[$];

  // Monitor on the inactive edge: counts writes and error pulses
  always @(negedge SysClk) begin
    if (Rst_n) begin
      if (Rx_Valid) begin
        n_valid = n_valid + 1;
        q_data.push_back(Rx_Data);
      end
      if (Err_Strobe) n_strobe = n_strobe + 1;
      if (Busy) busy_seen = 1'b1;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic [1:0] stops;     // [1] first stop bit on the line, [0] second
    logic       full;
    int         exp_nvalid;
    logic [7:0] exp_data;
    logic [2:0] exp_err;
    int         exp_nstrobe;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_valid   = 0;
    n_strobe  = 0;
    busy_seen = 1'b0;
    q_data.delete();
  endtask

  task automatic send_bit(input logic b);
    Rx = b;
    repeat (c_BIT) @(negedge SysClk);
  endtask

  // Sends the first nbits of start, D7..D0, parity, stop, stop
  task automatic send_frame(input logic [7:0] d, input logic p, input logic [1:0] s, input int nbits);
    logic [11:0] f;
    f = {1'b0, d, p, s};
    for (int i = 11; i > 11 - nbits; i--) send_bit(f[i]);
  endtask

  task automatic idle_bits(input int n);
    Rx = 1'b1;
    repeat (n * c_BIT) @(negedge SysClk);
  endtask

  logic [7:0] d0, d1;

  initial begin
    //            data   par   stops  full nval edata  eerr    nstb
    vecs[0] = '{8'hAA, 1'b0, 2'b11, 1'b0, 1, 8'hAA, 3'b000, 0};
    vecs[1] = '{8'hAB, 1'b0, 2'b11, 1'b0, 1, 8'hAB, 3'b001, 1};
    vecs[2] = '{8'h3C, 1'b0, 2'b01, 1'b0, 1, 8'h3C, 3'b010, 1};
    vecs[3] = '{8'hFF, 1'b0, 2'b11, 1'b0, 1, 8'hFF, 3'b000, 0};
    vecs[4] = '{8'h01, 1'b1, 2'b11, 1'b0, 1, 8'h01, 3'b000, 0};
    vecs[5] = '{8'h5A, 1'b0, 2'b11, 1'b1, 0, 8'h01, 3'b100, 1};

    Rx = 1'b1; FIFO_Full = 1'b0; Rst_n = 1'b0;
    clear_mon();
    repeat (5) @(negedge SysClk);
    check("reset_data",   {24'h0, Rx_Data},   32'h0);
    check("reset_valid",  {31'h0, Rx_Valid},  32'h0);
    check("reset_error",  {29'h0, Rx_Error},  32'h0);
    check("reset_strobe", {31'h0, Err_Strobe},32'h0);
    check("reset_busy",   {31'h0, Busy},      32'h0);
    Rst_n = 1'b1;
    idle_bits(2);

    for (int i = 0; i < 6; i++) begin
      clear_mon();
      FIFO_Full = vecs[i].full;
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stops, 12);
      FIFO_Full = 1'b0;
      idle_bits(2);
      check($sformatf("vec%0d_nvalid", i),  n_valid,               vecs[i].exp_nvalid);
      check($sformatf("vec%0d_data", i),    {24'h0, Rx_Data},      {24'h0, vecs[i].exp_data});
      check($sformatf("vec%0d_error", i),   {29'h0, Rx_Error},     {29'h0, vecs[i].exp_err});
      check($sformatf("vec%0d_nstrobe", i), n_strobe,              vecs[i].exp_nstrobe);
    end

    // Break: all-zero character with both stops low, line held low
    clear_mon();
    send_frame(8'h00, 1'b0, 2'b00, 12);
    busy_seen = 1'b0;
    repeat (3 * c_BIT) @(negedge SysClk);
    check("break_nvalid",  n_valid,           1);
    check("break_data",    {24'h0, Rx_Data},  32'h00);
    check("break_error",   {29'h0, Rx_Error}, 32'h2);
    check("break_nstrobe", n_strobe,          1);
    check("break_busy",    {31'h0, busy_seen},32'h0);
    idle_bits(2);
    clear_mon();
    send_frame(8'h11, 1'b0, 2'b11, 12);
    idle_bits(2);
    check("after_break_nvalid", n_valid,           1);
    check("after_break_data",   {24'h0, Rx_Data},  32'h11);
    check("after_break_error",  {29'h0, Rx_Error}, 32'h0);
    check("after_break_busy",   {31'h0, busy_seen},32'h1);

    // Glitch: low for a quarter bit
    clear_mon();
    Rx = 1'b0;
    repeat (c_BIT / 4) @(negedge SysClk);
    idle_bits(2);
    check("glitch_busy",    {31'h0, busy_seen},32'h0);
    check("glitch_nvalid",  n_valid,           0);
    check("glitch_nstrobe", n_strobe,          0);
    check("glitch_error",   {29'h0, Rx_Error}, 32'h0);

    // Back-to-back frames, then reset in the middle of a third
    clear_mon();
    send_frame(8'h55, 1'b0, 2'b11, 12);
    send_frame(8'h0F, 1'b0, 2'b11, 12);
    send_frame(8'hC3, 1'b0, 2'b11, 5);
    Rst_n = 1'b0;
    repeat (3) @(negedge SysClk);
    d0 = (q_data.size() > 0) ? q_data[0] : 8'hxx;
    d1 = (q_data.size() > 1) ? q_data[1] : 8'hxx;
    check("b2b_nvalid",     n_valid,            2);
    check("b2b_first",      {24'h0, d0},        32'h55);
    check("b2b_second",     {24'h0, d1},        32'h0F);
    check("rst_mid_data",   {24'h0, Rx_Data},   32'h0);
    check("rst_mid_valid",  {31'h0, Rx_Valid},  32'h0);
    check("rst_mid_error",  {29'h0, Rx_Error},  32'h0);
    check("rst_mid_strobe", {31'h0, Err_Strobe},32'h0);
    check("rst_mid_busy",   {31'h0, Busy},      32'h0);
    Rx = 1'b1;
    repeat (3) @(negedge SysClk);
    Rst_n = 1'b1;
    idle_bits(2);
    check("rst_after_nvalid", n_valid, 2);
    clear_mon();
    send_frame(8'hC3, 1'b0, 2'b11, 12);
    idle_bits(2);
    check("post_rst_nvalid",  n_valid,           1);
    check("post_rst_data",    {24'h0, Rx_Data},  32'hC3);
    check("post_rst_error",   {29'h0, Rx_Error}, 32'h0);
    check("post_rst_nstrobe", n_strobe,          0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
